// File: rtl/mcs4_ram.sv
// MCS-4 data RAM / output-port chip: decodes the A1..X3 instruction slots and executes SRC and RAM I/O opcodes.
// Optional macro MCS4_RAM_RESET_CLEAR_EN makes RESET_i also zero the RAM and status arrays.
module mcs4_ram #(
    parameter int         NUM_REGS   = 4,
    parameter int         NUM_CHARS  = 16,
    parameter int         NUM_STATUS = 4,
    parameter int         OUT_W      = 4,
    parameter logic [1:0] CHIP_ID    = 2'd0
) (
    input  logic             clk_i,
    input  logic             RESET_i,
    input  logic             PHI1_i,
    input  logic             PHI2_i,
    input  logic             SYNC_i,
    input  logic             CM_i,
    input  logic [3:0]       D_i,
    output logic [3:0]       D_o,
    output logic             D_oe_o,
    output logic [OUT_W-1:0] O_o
);

    localparam int CW         = $clog2(NUM_CHARS);
    localparam int RAM_AW     = $clog2(NUM_REGS * NUM_CHARS);
    localparam int STAT_PER   = (NUM_STATUS > 0) ? NUM_STATUS : 1;
    localparam int STAT_DEPTH = NUM_REGS * STAT_PER;
    localparam int STAT_AW    = (STAT_DEPTH > 1) ? $clog2(STAT_DEPTH) : 1;
    localparam logic [3:0] REG_MASK  = 4'((1 << NUM_REGS) - 1);
    localparam logic [3:0] STAT_MASK = 4'((1 << NUM_STATUS) - 1);

    typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} slot_t;

    slot_t               slot, slot_next;
    logic                prev_phi2, phi2_edge, abort;
    logic [3:0]          opa, char_idx, rd_val;
    logic [1:0]          reg_idx;
    logic                io_pend, sel, src_hit, chip_match;
    logic                reg_ok, stat_ok, is_ram_rd, is_stat_rd;
    logic                exec, ram_we, stat_we;
    logic [RAM_AW-1:0]   ram_addr;
    logic [STAT_AW-1:0]  stat_addr;
    logic [3:0]          ram_mem  [2**RAM_AW];
    logic [3:0]          stat_mem [2**STAT_AW];
    logic                unused_inputs;

    assign unused_inputs = ^{PHI1_i, char_idx};

    always_ff @(posedge clk_i) begin
        prev_phi2 <= PHI2_i;
    end

    // A SYNC seen anywhere but at the end of X3 is a mid-cycle abort.
    always_comb begin
        phi2_edge  = PHI2_i & ~prev_phi2;
        abort      = SYNC_i && (slot != X3);
        chip_match = (D_i[3:2] == CHIP_ID);
        reg_ok     = REG_MASK[reg_idx];
        stat_ok    = reg_ok && STAT_MASK[opa[1:0]];
        ram_addr   = RAM_AW'(int'(reg_idx) * NUM_CHARS + int'(char_idx[CW-1:0]));
        stat_addr  = STAT_AW'(int'(reg_idx) * STAT_PER + int'(opa[1:0]));
        is_ram_rd  = (opa == 4'h8) || (opa == 4'h9) || (opa == 4'hB);
        is_stat_rd = (opa[3:2] == 2'b11);
        rd_val     = 4'h0;
        if (is_ram_rd && reg_ok) begin
            rd_val = ram_mem[ram_addr];
        end else if (is_stat_rd && stat_ok) begin
            rd_val = stat_mem[stat_addr];
        end
        exec    = phi2_edge && !abort && !RESET_i && (slot == X2) && !CM_i && io_pend && sel;
        ram_we  = exec && (opa == 4'h0) && reg_ok;
        stat_we = exec && (opa[3:2] == 2'b01) && stat_ok;
    end

    always_ff @(posedge clk_i) begin
        if (RESET_i) begin
            slot <= A1;
        end else begin
            slot <= slot_next;
        end
    end

    always_comb begin
        slot_next = slot;
        if (phi2_edge) begin
            if (SYNC_i || (slot == X3)) begin
                slot_next = A1;
            end else begin
                slot_next = slot_t'(3'(slot + 3'd1));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (RESET_i) begin
            opa      <= 4'h0;
            io_pend  <= 1'b0;
            sel      <= 1'b0;
            src_hit  <= 1'b0;
            reg_idx  <= 2'd0;
            char_idx <= 4'h0;
            D_o      <= 4'h0;
            D_oe_o   <= 1'b0;
            O_o      <= '0;
        end else if (phi2_edge) begin
            if (abort) begin
                io_pend <= 1'b0;
                src_hit <= 1'b0;
                D_oe_o  <= 1'b0;
            end else begin
                case (slot)
                    M2: begin
                        if (CM_i) begin
                            opa     <= D_i;
                            io_pend <= 1'b1;
                        end else begin
                            io_pend <= 1'b0;
                        end
                    end
                    X1: begin
                        if (io_pend && sel && (is_ram_rd || is_stat_rd)) begin
                            D_oe_o <= 1'b1;
                            D_o    <= rd_val;
                        end
                    end
                    // CM high at X2 is always an SRC; otherwise a pending I/O executes.
                    X2: begin
                        D_oe_o <= 1'b0;
                        if (CM_i) begin
                            sel <= chip_match;
                            if (chip_match) begin
                                reg_idx <= D_i[1:0];
                                io_pend <= 1'b0;
                                src_hit <= 1'b1;
                            end
                        end else if (io_pend && sel) begin
                            io_pend <= 1'b0;
                            if (opa == 4'h1) begin
                                O_o <= D_i[OUT_W-1:0];
                            end
                        end
                    end
                    X3: begin
                        if (src_hit) begin
                            char_idx <= D_i;
                        end
                        src_hit <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef MCS4_RAM_RESET_CLEAR_EN
    always_ff @(posedge clk_i) begin
        if (RESET_i) begin
            for (int i = 0; i < 2**RAM_AW; i++) begin
                ram_mem[i] <= 4'h0;
            end
            for (int i = 0; i < 2**STAT_AW; i++) begin
                stat_mem[i] <= 4'h0;
            end
        end else begin
            if (ram_we) begin
                ram_mem[ram_addr] <= D_i;
            end
            if (stat_we) begin
                stat_mem[stat_addr] <= D_i;
            end
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            ram_mem[ram_addr] <= D_i;
        end
        if (stat_we) begin
            stat_mem[stat_addr] <= D_i;
        end
    end
`endif

endmodule

// File: tb/tb_mcs4_ram.sv
// Directed testbench for mcs4_ram: CHIP_ID=1, NUM_REGS=2, NUM_STATUS=2, OUT_W=2.
// Works with or without MCS4_RAM_RESET_CLEAR_EN defined.
module tb_mcs4_ram;

    logic       clk_i = 1'b0;
    logic       RESET_i = 1'b1;
    logic       PHI1_i = 1'b0;
    logic       PHI2_i = 1'b0;
    logic       SYNC_i = 1'b0;
    logic       CM_i = 1'b0;
    logic [3:0] D_i = 4'h0;
    logic [3:0] D_o;
    logic       D_oe_o;
    logic [1:0] O_o;

    int tests_run = 0;
    int tests_failed = 0;

    mcs4_ram #(
        .NUM_REGS(2), .NUM_CHARS(16), .NUM_STATUS(2), .OUT_W(2), .CHIP_ID(2'd1)
    ) dut (
        .clk_i(clk_i), .RESET_i(RESET_i), .PHI1_i(PHI1_i), .PHI2_i(PHI2_i),
        .SYNC_i(SYNC_i), .CM_i(CM_i), .D_i(D_i), .D_o(D_o), .D_oe_o(D_oe_o), .O_o(O_o)
    );

    always #5 clk_i = ~clk_i;

    // One bus slot: PHI1 pulse, then PHI2 pulse whose rise ends the slot; samples the bus mid-slot.
    task automatic do_slot(input logic sync, input logic cm, input logic [3:0] d,
                           output logic oe_mid, output logic [3:0] d_mid);
        @(negedge clk_i);
        SYNC_i = sync; CM_i = cm; D_i = d; PHI1_i = 1'b1;
        repeat (2) @(negedge clk_i);
        PHI1_i = 1'b0;
        @(negedge clk_i);
        oe_mid = D_oe_o; d_mid = D_o;
        PHI2_i = 1'b1;
        repeat (2) @(negedge clk_i);
        PHI2_i = 1'b0;
        SYNC_i = 1'b0;
    endtask

    task automatic run_cycle(input logic [3:0] m2_d, input logic cm_m2, input logic [3:0] x2_d,
                             input logic cm_x2, input logic [3:0] x3_d,
                             output logic oe_x1, output logic oe_x2, output logic [3:0] do_x2,
                             output logic oe_x3);
        logic oe;
        logic [3:0] dv;
        for (int s = 0; s < 4; s++) do_slot(1'b0, 1'b0, 4'h0, oe, dv);
        do_slot(1'b0, cm_m2, m2_d, oe, dv);
        do_slot(1'b0, 1'b0, 4'h0, oe_x1, dv);
        do_slot(1'b0, cm_x2, x2_d, oe_x2, do_x2);
        do_slot(1'b1, 1'b0, x3_d, oe_x3, dv);
    endtask

    task automatic src_cmd(input logic [3:0] hi, input logic [3:0] lo);
        logic a, b, c;
        logic [3:0] dv;
        run_cycle(4'h0, 1'b0, hi, 1'b1, lo, a, b, dv, c);
    endtask

    task automatic io_cmd(input logic [3:0] op, input logic [3:0] data,
                          output logic oe_x1, output logic oe_x2, output logic [3:0] do_x2,
                          output logic oe_x3);
        run_cycle(op, 1'b1, data, 1'b0, 4'h0, oe_x1, oe_x2, do_x2, oe_x3);
    endtask

    task automatic test_reset();
        logic a, b, c;
        logic [3:0] dv;
        @(negedge clk_i); RESET_i = 1'b1;
        @(negedge clk_i); RESET_i = 1'b0;
        tests_run++;
        if (D_oe_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_oe: got %b expected 0", D_oe_o); end
        tests_run++;
        if (O_o !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_port: got %b expected 00", O_o); end
        tests_run++;
        if (D_o !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_do: got %h expected 0", D_o); end
`ifdef MCS4_RAM_RESET_CLEAR_EN
        src_cmd(4'h4, 4'h0);
        io_cmd(4'h9, 4'h0, a, b, dv, c);
        tests_run++;
        if (b !== 1'b1 || dv !== 4'h0) begin
            tests_failed++; $display("[TB] FAIL reset_cleared_rdm: got oe=%b d=%h expected oe=1 d=0", b, dv);
        end
`else
        io_cmd(4'h9, 4'h0, a, b, dv, c);
        tests_run++;
        if (b !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_unselected: got oe=%b expected 0", b); end
`endif
    endtask

    task automatic test_write_read();
        logic oe1, oe2, oe3;
        logic [3:0] dv;
        src_cmd(4'h5, 4'hA);
        io_cmd(4'h0, 4'h9, oe1, oe2, dv, oe3);
        tests_run++;
        if (oe2 !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrm_no_drive: got %b expected 0", oe2); end
        io_cmd(4'h9, 4'h0, oe1, oe2, dv, oe3);
        tests_run++;
        if (oe1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL rdm_oe_x1: got %b expected 0", oe1); end
        tests_run++;
        if (oe2 !== 1'b1) begin tests_failed++; $display("[TB] FAIL rdm_oe_x2: got %b expected 1", oe2); end
        tests_run++;
        if (dv !== 4'h9) begin tests_failed++; $display("[TB] FAIL rdm_data: got %h expected 9", dv); end
        tests_run++;
        if (oe3 !== 1'b0) begin tests_failed++; $display("[TB] FAIL rdm_oe_x3: got %b expected 0", oe3); end
    endtask

    task automatic test_chip_mismatch();
        logic oe1, oe2, oe3;
        logic [3:0] dv;
        src_cmd(4'h0, 4'hA);
        io_cmd(4'h0, 4'h5, oe1, oe2, dv, oe3);
        io_cmd(4'h9, 4'h0, oe1, oe2, dv, oe3);
        tests_run++;
        if (oe2 !== 1'b0) begin tests_failed++; $display("[TB] FAIL mismatch_oe: got %b expected 0", oe2); end
        src_cmd(4'h5, 4'hA);
        io_cmd(4'h9, 4'h0, oe1, oe2, dv, oe3);
        tests_run++;
        if (oe2 !== 1'b1 || dv !== 4'h9) begin
            tests_failed++; $display("[TB] FAIL mismatch_no_write: got oe=%b d=%h expected oe=1 d=9", oe2, dv);
        end
    endtask

    task automatic test_status_port();
        logic oe1, oe2, oe3;
        logic [3:0] dv;
        io_cmd(4'h5, 4'h3, oe1, oe2, dv, oe3);
        io_cmd(4'h4, 4'hE, oe1, oe2, dv, oe3);
        io_cmd(4'hD, 4'h0, oe1, oe2, dv, oe3);
        tests_run++;
        if (oe2 !== 1'b1 || dv !== 4'h3) begin
            tests_failed++; $display("[TB] FAIL rd1: got oe=%b d=%h expected oe=1 d=3", oe2, dv);
        end
        io_cmd(4'hC, 4'h0, oe1, oe2, dv, oe3);
        tests_run++;
        if (dv !== 4'hE) begin tests_failed++; $display("[TB] FAIL rd0: got %h expected e", dv); end
        io_cmd(4'h1, 4'hF, oe1, oe2, dv, oe3);
        tests_run++;
        if (O_o !== 2'b11) begin tests_failed++; $display("[TB] FAIL wmp_f: got %b expected 11", O_o); end
        io_cmd(4'h1, 4'h6, oe1, oe2, dv, oe3);
        tests_run++;
        if (O_o !== 2'b10) begin tests_failed++; $display("[TB] FAIL wmp_6: got %b expected 10", O_o); end
    endtask

    task automatic test_range();
        logic oe1, oe2, oe3;
        logic [3:0] dv;
        io_cmd(4'h7, 4'h7, oe1, oe2, dv, oe3);
        io_cmd(4'hF, 4'h0, oe1, oe2, dv, oe3);
        tests_run++;
        if (oe2 !== 1'b1 || dv !== 4'h0) begin
            tests_failed++; $display("[TB] FAIL rd3_range: got oe=%b d=%h expected oe=1 d=0", oe2, dv);
        end
        io_cmd(4'h6, 4'h5, oe1, oe2, dv, oe3);
        io_cmd(4'hE, 4'h0, oe1, oe2, dv, oe3);
        tests_run++;
        if (dv !== 4'h0) begin tests_failed++; $display("[TB] FAIL rd2_range: got %h expected 0", dv); end
        src_cmd(4'h7, 4'hA);
        io_cmd(4'h0, 4'h2, oe1, oe2, dv, oe3);
        io_cmd(4'h9, 4'h0, oe1, oe2, dv, oe3);
        tests_run++;
        if (oe2 !== 1'b1 || dv !== 4'h0) begin
            tests_failed++; $display("[TB] FAIL reg3_range: got oe=%b d=%h expected oe=1 d=0", oe2, dv);
        end
        src_cmd(4'h5, 4'hA);
        io_cmd(4'h9, 4'h0, oe1, oe2, dv, oe3);
        tests_run++;
        if (dv !== 4'h9) begin tests_failed++; $display("[TB] FAIL reg3_no_alias: got %h expected 9", dv); end
    endtask

    task automatic test_back_to_back();
        logic oe1, oe2, oe3;
        logic [3:0] dv, op;
        for (int i = 0; i < 4; i++) begin
            src_cmd(4'h4, 4'(i));
            io_cmd(4'h0, 4'(3 * i + 1), oe1, oe2, dv, oe3);
        end
        for (int i = 0; i < 4; i++) begin
            op = (i == 1) ? 4'h8 : ((i == 3) ? 4'hB : 4'h9);
            src_cmd(4'h4, 4'(i));
            io_cmd(op, 4'h0, oe1, oe2, dv, oe3);
            tests_run++;
            if (oe2 !== 1'b1 || dv !== 4'(3 * i + 1)) begin
                tests_failed++;
                $display("[TB] FAIL b2b_char%0d: got oe=%b d=%h expected oe=1 d=%h", i, oe2, dv, 4'(3 * i + 1));
            end
        end
    endtask

    task automatic test_abort();
        logic oe, oe1, oe2, oe3;
        logic [3:0] dv;
        src_cmd(4'h5, 4'hA);
        for (int s = 0; s < 4; s++) do_slot(1'b0, 1'b0, 4'h0, oe, dv);
        do_slot(1'b0, 1'b1, 4'h9, oe, dv);
        do_slot(1'b0, 1'b0, 4'h0, oe, dv);
        do_slot(1'b1, 1'b0, 4'h0, oe, dv);
        tests_run++;
        if (oe !== 1'b1) begin tests_failed++; $display("[TB] FAIL abort_pre_oe: got %b expected 1", oe); end
        tests_run++;
        if (D_oe_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL sync_abort_oe: got %b expected 0", D_oe_o); end
        io_cmd(4'h9, 4'h0, oe1, oe2, dv, oe3);
        tests_run++;
        if (oe2 !== 1'b1 || dv !== 4'h9) begin
            tests_failed++; $display("[TB] FAIL sync_realign: got oe=%b d=%h expected oe=1 d=9", oe2, dv);
        end
        for (int s = 0; s < 4; s++) do_slot(1'b0, 1'b0, 4'h0, oe, dv);
        do_slot(1'b0, 1'b1, 4'h9, oe, dv);
        do_slot(1'b0, 1'b0, 4'h0, oe, dv);
        tests_run++;
        if (D_oe_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL pre_reset_oe: got %b expected 1", D_oe_o); end
        @(negedge clk_i); RESET_i = 1'b1;
        @(negedge clk_i); RESET_i = 1'b0;
        tests_run++;
        if (D_oe_o !== 1'b0 || D_o !== 4'h0 || O_o !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: got oe=%b d=%h o=%b expected oe=0 d=0 o=00", D_oe_o, D_o, O_o);
        end
        src_cmd(4'h5, 4'hA);
        io_cmd(4'h9, 4'h0, oe1, oe2, dv, oe3);
`ifdef MCS4_RAM_RESET_CLEAR_EN
        tests_run++;
        if (oe2 !== 1'b1 || dv !== 4'h0) begin
            tests_failed++; $display("[TB] FAIL post_reset_mem: got oe=%b d=%h expected oe=1 d=0", oe2, dv);
        end
`else
        tests_run++;
        if (oe2 !== 1'b1 || dv !== 4'h9) begin
            tests_failed++; $display("[TB] FAIL post_reset_mem: got oe=%b d=%h expected oe=1 d=9", oe2, dv);
        end
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        test_reset();
        test_write_read();
        test_chip_mismatch();
        test_status_port();
        test_range();
        test_back_to_back();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
